// File: rtl/temp_pkg.sv
// Shared types and constants for the on-die temperature sampling path.
package temp_pkg;

  localparam int          TEMP_W    = 12;
  localparam int          CH_W      = 5;
  localparam logic [11:0] TEMP_IDLE = 12'hFFF;

  typedef enum logic {
    S_WARM = 1'b0,
    S_RUN  = 1'b1
  } temp_avg_state_t;

endpackage

// File: rtl/temp_stall_timer.sv
// Saturating idle-cycle counter; flags a stalled ADC after STALL_CYCLES quiet cycles.
module temp_stall_timer #(
  parameter int STALL_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic stall_o
);

  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;
  logic             stall_q, stall_d;

  // Next count: restart wins, otherwise count up and hold at the limit.
  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
    stall_d = (count_d == CNT_MAX);
  end

  // Counter and stall flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      stall_q <= 1'b0;
    end else begin
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

  assign stall_o = stall_q;

endmodule

// File: rtl/temp_sample_avg.sv
// Filters ADC beats to the temperature channel and box-averages 2^AVG_LOG2 of them.
// Optional hottest-reading hold register enabled by TEMP_PEAK_HOLD_EN.
module temp_sample_avg
  import temp_pkg::*;
#(
  parameter int               AVG_LOG2     = 3,
  parameter logic [CH_W-1:0]  CHANNEL      = 5'd0,
  parameter int               STALL_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_valid,
  input  logic [CH_W-1:0]   adc_channel,
  input  logic [TEMP_W-1:0] adc_data,
  input  logic              clear,
  output logic [TEMP_W-1:0] temp,
  output logic              temp_valid,
  output logic              temp_ready,
  output logic              adc_stall
`ifdef TEMP_PEAK_HOLD_EN
  ,
  output logic [TEMP_W-1:0] temp_peak
`endif
);

  localparam int ACC_W = TEMP_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] LAST_CNT = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]    acc_q, acc_d, sum_s;
  logic [AVG_LOG2:0]   cnt_q, cnt_d;
  logic [TEMP_W-1:0]   temp_q, temp_d, avg_s;
  logic                valid_q, valid_d;
  temp_avg_state_t     state_q, state_d;
  logic                accept_s, complete_s;

  assign accept_s   = adc_valid && (adc_channel == CHANNEL) && !clear;
  assign complete_s = accept_s && (cnt_q == LAST_CNT);
  assign sum_s      = acc_q + ACC_W'(adc_data);
  assign avg_s      = TEMP_W'(sum_s >> AVG_LOG2);

  // Window accumulation; completion folds the last sample in and reopens the window.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    temp_d  = temp_q;
    valid_d = 1'b0;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (complete_s) begin
      acc_d   = '0;
      cnt_d   = '0;
      temp_d  = avg_s;
      valid_d = 1'b1;
    end else if (accept_s) begin
      acc_d = sum_s;
      cnt_d = cnt_q + (AVG_LOG2 + 1)'(1);
    end else begin
      acc_d = acc_q;
    end
  end

  // Warm-up FSM: leaves S_WARM on the first completed window, then stays.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WARM: begin
        if (complete_s) state_d = S_RUN;
        else            state_d = S_WARM;
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_WARM;
    endcase
  end

  // Datapath and state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      temp_q  <= TEMP_IDLE;
      valid_q <= 1'b0;
      state_q <= S_WARM;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      temp_q  <= temp_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

`ifdef TEMP_PEAK_HOLD_EN
  logic [TEMP_W-1:0] peak_q, peak_d;

  // Lower code is hotter, so the peak tracks the minimum average.
  always_comb begin
    peak_d = peak_q;
    if (complete_s && (avg_s < peak_q)) begin
      peak_d = avg_s;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= TEMP_IDLE;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign temp_peak = peak_q;
`endif

  temp_stall_timer #(
    .STALL_CYCLES(STALL_CYCLES)
  ) u_stall (
    .clk      (clk),
    .rst      (rst),
    .restart_i(accept_s || clear),
    .stall_o  (adc_stall)
  );

  assign temp       = temp_q;
  assign temp_valid = valid_q;
  assign temp_ready = (state_q == S_RUN);

endmodule

// File: tb/tb_temp_sample_avg.sv
// Directed self-checking bench for temp_sample_avg (AVG_LOG2=3, CHANNEL=0, STALL_CYCLES=100).
module tb_temp_sample_avg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        adc_valid = 1'b0;
  logic [4:0]  adc_channel = 5'd0;
  logic [11:0] adc_data = 12'd0;
  logic        clear = 1'b0;
  logic [11:0] temp;
  logic        temp_valid;
  logic        temp_ready;
  logic        adc_stall;
`ifdef TEMP_PEAK_HOLD_EN
  logic [11:0] temp_peak;
`endif

  int n_cmp = 0;
  int n_err = 0;

  temp_sample_avg #(
    .AVG_LOG2(3),
    .CHANNEL(5'd0),
    .STALL_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_valid  (adc_valid),
    .adc_channel(adc_channel),
    .adc_data   (adc_data),
    .clear      (clear),
    .temp       (temp),
    .temp_valid (temp_valid),
    .temp_ready (temp_ready),
    .adc_stall  (adc_stall)
`ifdef TEMP_PEAK_HOLD_EN
    ,
    .temp_peak  (temp_peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are then sampled 1 time unit after the edge.
  task automatic step(input logic v, input logic [4:0] ch, input logic [11:0] d, input logic c);
    adc_valid   = v;
    adc_channel = ch;
    adc_data    = d;
    clear       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 12'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "time limit reached");
  end

  initial begin
    // Reset values
    #1;
    do_reset();
    chk("rst_temp", temp, 12'hFFF);
    chk("rst_valid", temp_valid, 1'b0);
    chk("rst_ready", temp_ready, 1'b0);
    chk("rst_stall", adc_stall, 1'b0);
`ifdef TEMP_PEAK_HOLD_EN
    chk("rst_peak", temp_peak, 12'hFFF);
`endif

    // Steady window of 3600, then continued stream
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 5'd0, 12'd3600, 1'b0);
      chk("steady_nopulse", temp_valid, 1'b0);
    end
    chk("steady_temp_hold", temp, 12'hFFF);
    chk("steady_warm", temp_ready, 1'b0);
    step(1'b1, 5'd0, 12'd3600, 1'b0);
    chk("steady_temp", temp, 12'd3600);
    chk("steady_pulse", temp_valid, 1'b1);
    chk("steady_ready", temp_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'd0, 12'd3600, 1'b0);
      chk("stream_pulse", temp_valid, (i == 7) ? 1'b1 : 1'b0);
    end
    idle(1);
    chk("stream_pulse_end", temp_valid, 1'b0);
    chk("stream_temp", temp, 12'd3600);

    // Truncation after a fresh reset
    do_reset();
    chk("rst2_temp", temp, 12'hFFF);
    chk("rst2_ready", temp_ready, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 5'd0, 12'(3640 + i), 1'b0);
    chk("trunc_temp", temp, 12'd3643);
    chk("trunc_pulse", temp_valid, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 5'd0, 12'd3700, 1'b0);
    chk("trunc_next_temp", temp, 12'd3700);
`ifdef TEMP_PEAK_HOLD_EN
    chk("peak_hold", temp_peak, 12'd3643);
`endif

    // Channel filter
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 5'd0, 12'd1000, 1'b0);
      chk("chan_nopulse_a", temp_valid, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5'd3, 12'd0, 1'b0);
      chk("chan_nopulse_b", temp_valid, 1'b0);
    end
    chk("chan_temp_hold", temp, 12'd3700);
    step(1'b1, 5'd0, 12'd1000, 1'b0);
    chk("chan_temp", temp, 12'd1000);
    chk("chan_pulse", temp_valid, 1'b1);
`ifdef TEMP_PEAK_HOLD_EN
    chk("peak_update", temp_peak, 12'd1000);
`endif

    // Clear colliding with the 4th sample
    for (int i = 0; i < 3; i++) step(1'b1, 5'd0, 12'd500, 1'b0);
    step(1'b1, 5'd0, 12'd500, 1'b1);
    chk("clr_ready", temp_ready, 1'b1);
    chk("clr_temp_keep", temp, 12'd1000);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 5'd0, 12'd2000, 1'b0);
      chk("clr_nopulse", temp_valid, 1'b0);
    end
    chk("clr_temp_old", temp, 12'd1000);
    step(1'b1, 5'd0, 12'd2000, 1'b0);
    chk("clr_temp_new", temp, 12'd2000);
    chk("clr_pulse", temp_valid, 1'b1);
`ifdef TEMP_PEAK_HOLD_EN
    chk("peak_keep", temp_peak, 12'd1000);
`endif

    // Stall timer
    do_reset();
    idle(99);
    chk("stall_99", adc_stall, 1'b0);
    idle(1);
    chk("stall_100", adc_stall, 1'b1);
    idle(5);
    chk("stall_sat", adc_stall, 1'b1);
    step(1'b1, 5'd0, 12'd100, 1'b0);
    chk("stall_fall", adc_stall, 1'b0);
    idle(50);
    step(1'b0, 5'd0, 12'd0, 1'b1);
    idle(60);
    chk("stall_clr_restart", adc_stall, 1'b0);
    idle(39);
    chk("stall_clr_99", adc_stall, 1'b0);
    idle(1);
    chk("stall_clr_100", adc_stall, 1'b1);
    step(1'b1, 5'd3, 12'd0, 1'b0);
    chk("stall_other_ch", adc_stall, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
